pipe_chain_arst_en: RTL and testbench
=====================================

# pipe_chain_arst_en

Parametrised elastic pipeline register chain: DEPTH stages of DATA_W-bit data, each with its own valid bit, a valid/ready handshake on both ends, and per-stage flush. Successor of the single-stage enable register used between processor pipeline stages (IF/ID, ID/EX, ...). Adds multi-stage depth, bubble collapsing under back-pressure, selective kill of in-flight entries, and an occupancy count. Sits between a producer stage and a consumer stage; a global enable can freeze it.

## Interface
Parameters:
- DATA_W, 32, payload width in bits (>= 1)
- DEPTH, 3, number of register stages (>= 1)
- PRESET_VAL, 0, value loaded into every data register on reset
- CNT_W, $clog2(DEPTH+1), width of the occupancy output (derived, not overridden)

Ports:
- clk  in  1  clock; all state updates on its rising edge
- arst  in  1  reset, asynchronous, active-high; one clock domain only
- en  in  1  global enable; 0 freezes all transfers
- in_valid  in  1  producer has a word on in_data
- in_ready  out  1  chain accepts in_data this cycle (combinational)
- in_data  in  DATA_W  producer payload
- flush  in  DEPTH  bit i kills the entry currently held in stage i
- out_valid  out  1  stage DEPTH-1 holds a live entry (combinational)
- out_ready  in  1  consumer accepts out_data this cycle
- out_data  out  DATA_W  data register of stage DEPTH-1
- occupancy  out  CNT_W  number of stages with valid set (registered)

## Operation
- Per stage i: data register d[i], valid bit v[i]. Stage 0 is the input end, stage DEPTH-1 the output end.
- Live entry: live[i] = v[i] & ~flush[i].
- Ready chain, computed combinationally from the output end: rdy[DEPTH] = out_ready; rdy[i] = en & (~live[i] | rdy[i+1]).
  - A flushed stage counts as empty, so the entry above it may move in during the same cycle.
- in_ready = rdy[0]. An input transfer happens when in_valid & in_ready.
- Stage transfers:
  - Stage i-1 moves into stage i when live[i-1] & rdy[i].
  - Stage 0 is loaded from the input on an input transfer.
- out_valid = live[DEPTH-1]. An output transfer happens when out_valid & out_ready & en.
- Next state of stage i:
  - If an entry moves in: d[i] takes the incoming data and v[i] is set to 1.
  - Otherwise, if the stage's entry leaves or flush[i] = 1: v[i] is cleared to 0 and d[i] holds.
  - Otherwise the stage holds.
- Flush acts even when en = 0: the valid bit is cleared and nothing moves.
- en = 0: in_ready = 0 and no transfers occur. out_valid still reflects live[DEPTH-1]; the consumer must not take data while en = 0.
- Data registers load only on a move-in. Empty stages keep stale data; out_data is d[DEPTH-1] unconditionally.
- occupancy is the popcount of the next-state valid bits, registered. It equals the popcount of v[] at all times.
- DEPTH = 1 degenerates to a single register with a skid-free handshake. in_ready = en & (~live[0] | out_ready).

## Timing
- Reset (arst = 1, asynchronous, effective immediately) leaves the block in this state:
  - all v = 0, all d = PRESET_VAL, occupancy = 0
  - out_valid = 0, out_data = PRESET_VAL
  - in_ready = en (combinational)
- Reset released mid-stream: all in-flight entries are lost. The first rising edge after deassertion may accept input.
- Latency: a word accepted at edge N is presented on out_valid after edge N+DEPTH-1, i.e. DEPTH cycles from in_valid assertion, provided out_ready = 1 throughout.
- Throughput: one word per cycle when out_ready = 1 and en = 1.
- Back-pressure (out_ready = 0): entries advance into empty stages, collapsing bubbles. in_ready falls only when all DEPTH stages are live.
- Full chain with out_ready = 1: the output transfer and the input transfer happen in the same cycle, and occupancy stays DEPTH.
- Flush on the output stage in the same cycle as out_ready = 1: no output transfer occurs; the entry is discarded.
- Simultaneous flush of stage i and move-in from stage i-1: the incoming entry survives and v[i] = 1.

## Test plan
Bench settings: DATA_W = 8, DEPTH = 3, PRESET_VAL = 8'hA5.
- Reset: assert arst asynchronously mid-cycle → out_data = A5, out_valid = 0 and occupancy = 0 immediately, with no clock edge.
- Streaming: in_valid = 1 with values 01, 02, 03, 04 on consecutive cycles, out_ready = 1 → out_valid rises 3 cycles after 01 is accepted; outputs appear in order 01–04 with no gaps; occupancy peaks at 3.
- Back-pressure:
  - Stimulus: send 10, then one idle cycle, then 11, 12, 13, with out_ready = 0.
  - Required response: the bubble collapses; occupancy reaches 3; in_ready = 0 while 13 is still waiting.
  - Then raise out_ready for one cycle: 10 leaves, 13 enters the same cycle, and occupancy stays 3.
- Flush: full chain holding 20 (stage 2), 21 (stage 1), 22 (stage 0); pulse flush = 3'b010 with out_ready = 0 → occupancy becomes 2; then draining yields 20, 22 only.
- Flush versus output: flush = 3'b100 while out_ready = 1 → no output handshake occurs; the next word out is the former stage-1 entry.
- Enable: en = 0 for 4 cycles with traffic on both sides → no state change and in_ready = 0; a flush applied during this window still clears its stage.

Source files
------------

// File: rtl/pipe_chain_arst_en.sv
// rtl/pipe_chain_arst_en.sv - elastic multi-stage register chain with valid/ready, per-stage flush and occupancy
module pipe_chain_arst_en #(
  parameter int                 DATA_W     = 32,
  parameter int                 DEPTH      = 3,
  parameter logic [DATA_W-1:0]  PRESET_VAL = '0,
  localparam int                CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DEPTH-1:0]  flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  occupancy
);

  logic [DATA_W-1:0] d   [DEPTH];
  logic [DATA_W-1:0] src [DEPTH];
  logic [DEPTH-1:0]  v;
  logic [DEPTH-1:0]  live;
  logic [DEPTH-1:0]  rdy;
  logic [DEPTH-1:0]  move_in;
  logic [DEPTH-1:0]  leave;
  logic [DEPTH-1:0]  v_next;
  logic [CNT_W-1:0]  cnt_next;

  // A flushed entry is treated as already gone for this cycle.
  assign live = v & ~flush;

  // Stage i can take a word if any stage from i to the output end is free,
  // or the consumer drains the end; this is the unrolled form of the ready chain.
  always_comb begin : ready_chain
    logic hole;
    hole = out_ready;
    rdy  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      hole   = hole | ~live[i];
      rdy[i] = en & hole;
    end
  end

  // Per-stage move-in / leave decisions and the incoming data for each stage.
  always_comb begin
    move_in    = '0;
    leave      = '0;
    src[0]     = in_data;
    move_in[0] = in_valid & rdy[0];
    for (int i = 1; i < DEPTH; i++) begin
      src[i]     = d[i-1];
      move_in[i] = live[i-1] & rdy[i];
    end
    for (int i = 0; i < DEPTH - 1; i++) begin
      leave[i] = live[i] & rdy[i+1];
    end
    leave[DEPTH-1] = live[DEPTH-1] & out_ready & en;
  end

  // Next valid bits: an arriving entry wins over a flush of the same stage.
  always_comb begin
    v_next   = '0;
    cnt_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      v_next[i] = move_in[i] | (v[i] & ~leave[i] & ~flush[i]);
      cnt_next  = cnt_next + CNT_W'(v_next[i]);
    end
  end

  // Valid bits and registered occupancy count.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      v         <= '0;
      occupancy <= '0;
    end else begin
      v         <= v_next;
      occupancy <= cnt_next;
    end
  end

  // Data registers load only when an entry moves in; empty stages keep stale data.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int i = 0; i < DEPTH; i++) begin
        d[i] <= PRESET_VAL;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (move_in[i]) begin
          d[i] <= src[i];
        end
      end
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = live[DEPTH-1];
  assign out_data  = d[DEPTH-1];

endmodule

// File: tb/tb_pipe_chain_arst_en.sv
// tb/tb_pipe_chain_arst_en.sv - self-checking bench for pipe_chain_arst_en
module tb_pipe_chain_arst_en;

  localparam int         DW = 8;
  localparam int         DP = 3;
  localparam logic [7:0] PV = 8'hA5;

  logic          clk = 1'b0;
  logic          arst;
  logic          en;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [DP-1:0] flush;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;

  pipe_chain_arst_en #(.DATA_W(DW), .DEPTH(DP), .PRESET_VAL(PV)) dut (
    .clk(clk), .arst(arst), .en(en),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int peak     = 0;

  // Reference: slot array, index 2 is the output end.
  logic [7:0] md [3];
  bit         mv [3];

  logic [7:0] outs[$];
  int         out_cyc[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] out_at(input int k);
    if (k < outs.size()) return {24'h0, outs[k]};
    return 32'hDEAD_BEEF;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      md[i] = PV;
      mv[i] = 1'b0;
    end
  endtask

  // One clock cycle: check combinational/registered outputs against the slot
  // model at the falling edge, then commit the model at the rising edge.
  task automatic cycle();
    logic [7:0] nd [3];
    bit         nv [3];
    bit         eir;
    int         cnt;
    @(negedge clk);
    nv  = mv;
    nd  = md;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (flush[i]) nv[i] = 1'b0;
      cnt += int'(mv[i]);
    end
    check("occupancy", {30'h0, occupancy}, cnt);
    check("out_valid", {31'h0, out_valid}, {31'h0, nv[2]});
    check("out_data", {24'h0, out_data}, {24'h0, md[2]});
    eir = 1'b0;
    if (en) begin
      if (nv[2] && out_ready) nv[2] = 1'b0;
      for (int i = 2; i >= 1; i--) begin
        if (!nv[i] && nv[i-1]) begin
          nv[i]   = 1'b1;
          nd[i]   = nd[i-1];
          nv[i-1] = 1'b0;
        end
      end
      eir = !nv[0];
      if (in_valid && eir) begin
        nv[0] = 1'b1;
        nd[0] = in_data;
      end
    end
    check("in_ready", {31'h0, in_ready}, {31'h0, eir});
    if (int'(occupancy) > peak) peak = int'(occupancy);
    if (out_valid && out_ready && en) begin
      outs.push_back(out_data);
      out_cyc.push_back(cyc);
    end
    @(posedge clk);
    mv = nv;
    md = nd;
    cyc++;
    #1;
  endtask

  task automatic send(input logic [7:0] val);
    in_valid = 1'b1;
    in_data  = val;
    cycle();
    in_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int start;
    arst = 1'b1; en = 1'b1; in_valid = 1'b0; in_data = '0; flush = '0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_data", {24'h0, out_data}, {24'h0, PV});
    check("rst_out_valid", {31'h0, out_valid}, 0);
    check("rst_occupancy", {30'h0, occupancy}, 0);
    check("rst_in_ready", {31'h0, in_ready}, 1);
    arst = 1'b0;

    // Streaming with the consumer always ready.
    outs.delete(); out_cyc.delete(); peak = 0;
    out_ready = 1'b1;
    start = cyc;
    for (int k = 1; k <= 4; k++) send(8'(k));
    repeat (5) cycle();
    check("stream_count", outs.size(), 4);
    for (int k = 0; k < 4; k++) begin
      check("stream_order", out_at(k), k + 1);
      check("stream_timing", (k < out_cyc.size()) ? out_cyc[k] : -1, start + 3 + k);
    end
    check("stream_peak", peak, 3);

    // Back-pressure: bubble collapses, then simultaneous in/out on a full chain.
    outs.delete();
    out_ready = 1'b0;
    send(8'h10);
    cycle();
    send(8'h11);
    send(8'h12);
    in_valid = 1'b1; in_data = 8'h13;
    #1;
    check("bp_full_in_ready", {31'h0, in_ready}, 0);
    check("bp_full_occ", {30'h0, occupancy}, 3);
    cycle();
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    check("bp_swap_out", out_at(0), 32'h10);
    check("bp_swap_occ", {30'h0, occupancy}, 3);
    repeat (4) cycle();
    check("bp_count", outs.size(), 4);
    for (int k = 0; k < 4; k++) check("bp_order", out_at(k), 32'h10 + k);

    // Flush of the middle stage.
    outs.delete();
    out_ready = 1'b0;
    send(8'h20); send(8'h21); send(8'h22);
    check("fl_full_occ", {30'h0, occupancy}, 3);
    flush = 3'b010;
    cycle();
    flush = 3'b000;
    check("fl_occ", {30'h0, occupancy}, 2);
    out_ready = 1'b1;
    repeat (4) cycle();
    check("fl_count", outs.size(), 2);
    check("fl_first", out_at(0), 32'h20);
    check("fl_second", out_at(1), 32'h22);

    // Flush of the output stage while the consumer is ready.
    outs.delete();
    out_ready = 1'b0;
    send(8'h30); send(8'h31); send(8'h32);
    flush = 3'b100; out_ready = 1'b1;
    cycle();
    flush = 3'b000;
    check("flo_no_xfer", outs.size(), 0);
    repeat (4) cycle();
    check("flo_count", outs.size(), 2);
    check("flo_first", out_at(0), 32'h31);
    check("flo_second", out_at(1), 32'h32);

    // Global enable low: frozen, but flush still acts.
    outs.delete();
    out_ready = 1'b0;
    send(8'h40); send(8'h41);
    cycle();
    en = 1'b0; in_valid = 1'b1; in_data = 8'h42; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      flush = (k == 2) ? 3'b010 : 3'b000;
      #1;
      check("en_in_ready", {31'h0, in_ready}, 0);
      cycle();
    end
    flush = 3'b000;
    check("en_no_xfer", outs.size(), 0);
    check("en_occ", {30'h0, occupancy}, 1);
    en = 1'b1; in_valid = 1'b0;
    repeat (4) cycle();
    check("en_count", outs.size(), 1);
    check("en_out", out_at(0), 32'h40);

    // Asynchronous reset mid-cycle with entries in flight.
    out_ready = 1'b0;
    send(8'h50); send(8'h51);
    #2;
    arst = 1'b1;
    #1;
    check("arst_out_data", {24'h0, out_data}, {24'h0, PV});
    check("arst_out_valid", {31'h0, out_valid}, 0);
    check("arst_occupancy", {30'h0, occupancy}, 0);
    check("arst_in_ready", {31'h0, in_ready}, 1);
    model_reset();
    @(posedge clk);
    #1;
    arst = 1'b0;
    send(8'h55);
    check("arst_accept_occ", {30'h0, occupancy}, 1);

    // Randomized traffic against the slot model.
    for (int n = 0; n < 400; n++) begin
      en        = ($urandom_range(0, 9) != 0);
      in_valid  = $urandom_range(0, 1);
      out_ready = $urandom_range(0, 1);
      in_data   = 8'($urandom);
      for (int i = 0; i < DP; i++) flush[i] = ($urandom_range(0, 7) == 0);
      cycle();
    end
    en = 1'b1; in_valid = 1'b0; flush = '0; out_ready = 1'b1;
    repeat (4) cycle();
    check("final_occ", {30'h0, occupancy}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
